// File: rtl/io_port_pkg.sv
// Shared I/O port constants: write/read Empty-Full bit meanings, default word widths
// and the overflow-count width.
package io_port_pkg;

  localparam logic IO_EF_FULL  = 1'b1;
  localparam logic IO_EF_EMPTY = 1'b0;

  localparam int unsigned IO_A_WORD_WIDTH     = 36;
  localparam int unsigned IO_B_WORD_WIDTH     = 36;
  localparam int unsigned IO_OVF_COUNT_WIDTH  = 16;

endpackage

// File: rtl/io_sat_counter.sv
// Width-parameterised saturating incrementer with synchronous active-low clear.
module io_sat_counter
  import io_port_pkg::*;
#(
  parameter int unsigned WIDTH = IO_OVF_COUNT_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/io_write_port_fifo.sv
// Per-port I/O write buffer with first-word fall-through drain and registered write_EF.
// Optional dropped-write counter enabled by IO_WRITE_FIFO_OVF_COUNT_EN.
module io_write_port_fifo
  import io_port_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = IO_A_WORD_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wren,
  input  logic [WORD_WIDTH-1:0]         write_data,
  output logic                          write_EF,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IO_OVF_COUNT_WIDTH-1:0] overflow_count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  push;
  logic                  pop;

  // All status outputs decode registered occupancy only; no wren/out_ready path.
  always_comb begin
    write_EF  = (count == FULL_COUNT) ? IO_EF_FULL : IO_EF_EMPTY;
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    push      = wren & (write_EF == IO_EF_EMPTY);
    pop       = out_valid & out_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= write_data;
  end

`ifdef IO_WRITE_FIFO_OVF_COUNT_EN
  logic ovf_hit;

  always_comb ovf_hit = wren & (write_EF == IO_EF_FULL);

  io_sat_counter #(
    .WIDTH(IO_OVF_COUNT_WIDTH)
  ) u_ovf_counter (
    .clock   (clock),
    .clear_n (reset_n),
    .inc     (ovf_hit),
    .count   (overflow_count)
  );
`else
  assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_io_write_port_fifo.sv
// Bench for io_write_port_fifo: queue-based reference model plus directed literal checks.
module tb_io_write_port_fifo;

`ifdef IO_WRITE_FIFO_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wren = 1'b0;
  logic [35:0] write_data = '0;
  logic        write_EF;
  logic [35:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] overflow_count;

  int checks = 0;
  int errors = 0;

  logic [35:0] q[$];
  int          ovf = 0;

  io_write_port_fifo #(
    .WORD_WIDTH(36),
    .DEPTH(4),
    .ADDR_WIDTH(2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wren           (wren),
    .write_data     (write_data),
    .write_EF       (write_EF),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow_count (overflow_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("write_EF", 64'(write_EF), 64'(q.size() == DEPTH));
    if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
    chk("overflow_count", 64'(overflow_count), OVF_EN ? 64'(ovf) : 64'd0);
  endtask

  // Drive one cycle at negedge, apply the rules at posedge, compare at next negedge.
  task automatic cycle(input logic w, input logic [35:0] d, input logic r, input logic rst_n);
    bit full, valid;
    reset_n    = rst_n;
    wren       = w;
    write_data = d;
    out_ready  = r;
    @(posedge clock);
    if (!rst_n) begin
      q.delete();
      ovf = 0;
    end else begin
      full  = (q.size() == DEPTH);
      valid = (q.size() != 0);
      if (w && full && ovf < 65535) ovf++;
      if (valid && r) void'(q.pop_front());
      if (w && !full) q.push_back(d);
    end
    @(negedge clock);
    model_compare();
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    @(negedge clock);
    do_reset();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst write_EF", 64'(write_EF), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst overflow", 64'(overflow_count), 64'd0);

    // 1: single write, one-cycle latency
    cycle(1'b1, 36'h1, 1'b0, 1'b1);
    chk("t1 out_valid", 64'(out_valid), 64'd1);
    chk("t1 out_data", 64'(out_data), 64'h1);
    chk("t1 write_EF", 64'(write_EF), 64'd0);

    // 2: fill, drop fifth, drain in order
    do_reset();
    cycle(1'b1, 36'hA, 1'b0, 1'b1);
    cycle(1'b1, 36'hB, 1'b0, 1'b1);
    cycle(1'b1, 36'hC, 1'b0, 1'b1);
    chk("t2 not full at 3", 64'(write_EF), 64'd0);
    cycle(1'b1, 36'hD, 1'b0, 1'b1);
    chk("t2 full", 64'(write_EF), 64'd1);
    cycle(1'b1, 36'hE, 1'b0, 1'b1);
    chk("t2 head after drop", 64'(out_data), 64'hA);
    for (int i = 0; i < 4; i++) begin
      chk("t2 drain", 64'(out_data), 64'hA + 64'(i));
      cycle(1'b0, '0, 1'b1, 1'b1);
    end
    chk("t2 empty", 64'(out_valid), 64'd0);

    // 3: full with simultaneous write and pop
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 36'hA + 36'(i), 1'b0, 1'b1);
    cycle(1'b1, 36'hF, 1'b1, 1'b1);
    chk("t3 head", 64'(out_data), 64'hB);
    chk("t3 write_EF", 64'(write_EF), 64'd0);
    chk("t3 overflow", 64'(overflow_count), OVF_EN ? 64'd1 : 64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) n++;
      cycle(1'b0, '0, 1'b1, 1'b1);
    end
    chk("t3 remaining", 64'(n), 64'd3);

    // 4: steady stream
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 36'd100 + 36'(i), 1'b1, 1'b1);
      chk("t4 stream data", 64'(out_data), 64'd100 + 64'(i));
      chk("t4 single entry", 64'(write_EF), 64'd0);
    end

    // 5: reset mid-operation while writing
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 36'h50 + 36'(i), 1'b0, 1'b1);
    cycle(1'b1, 36'h77, 1'b0, 1'b0);
    chk("t5 out_valid", 64'(out_valid), 64'd0);
    chk("t5 write_EF", 64'(write_EF), 64'd0);
    cycle(1'b1, 36'h99, 1'b0, 1'b1);
    chk("t5 new data", 64'(out_data), 64'h99);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("t5 sole entry", 64'(out_valid), 64'd0);

    // 6: overflow accumulation
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 36'(i), 1'b0, 1'b1);
`ifdef IO_WRITE_FIFO_OVF_COUNT_EN
    for (int i = 0; i < 70000; i++) cycle(1'b1, 36'h3C, 1'b0, 1'b1);
    chk("t6 saturated", 64'(overflow_count), 64'hFFFF);
`else
    for (int i = 0; i < 10; i++) cycle(1'b1, 36'h3C, 1'b0, 1'b1);
    chk("t6 tied zero", 64'(overflow_count), 64'd0);
`endif

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), {$urandom(), 4'($urandom())},
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 60) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
